// File: rtl/multicycle_controller_pkg.sv
// rtl/multicycle_controller_pkg.sv - shared states, ALU codes, opcodes and select encodings
package multicycle_controller_pkg;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXEC_R    = 4'd6,
    S_EXEC_I    = 4'd7,
    S_ALU_WB    = 4'd8,
    S_BRANCH    = 4'd9,
    S_JUMP      = 4'd10,
    S_UPPER     = 4'd11,
    S_TRAP      = 4'd12
  } state_t;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLT  = 4'd5,
    ALU_SLTU = 4'd6,
    ALU_SLL  = 4'd7,
    ALU_SRL  = 4'd8,
    ALU_SRA  = 4'd9
  } alu_op_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [1:0] SRC_A_PC     = 2'b00;
  localparam logic [1:0] SRC_A_OLD_PC = 2'b01;
  localparam logic [1:0] SRC_A_RS1    = 2'b10;

  localparam logic [1:0] SRC_B_RS2  = 2'b00;
  localparam logic [1:0] SRC_B_IMM  = 2'b01;
  localparam logic [1:0] SRC_B_FOUR = 2'b10;

  localparam logic [1:0] RES_ALU     = 2'b00;
  localparam logic [1:0] RES_MEM     = 2'b01;
  localparam logic [1:0] RES_ALU_OUT = 2'b10;

  localparam logic ADDR_PC  = 1'b0;
  localparam logic ADDR_ALU = 1'b1;

endpackage

// File: rtl/multicycle_controller_if.sv
// rtl/multicycle_controller_if.sv - controller to datapath signal bundle
interface multicycle_controller_if #(
  parameter int ALU_CTRL_W = 4
);
  logic [6:0]            opcode;
  logic [2:0]            funct3;
  logic                  funct7b5;
  logic                  zero;
  logic                  negative;
  logic                  carry;
  logic                  overflow;
  logic                  mem_ready;
  logic                  PC_write;
  logic                  IR_write;
  logic                  mem_read;
  logic                  mem_write;
  logic                  reg_write;
  logic                  address_select;
  logic [1:0]            ALU_src_A;
  logic [1:0]            ALU_src_B;
  logic [1:0]            result_select;
  logic [ALU_CTRL_W-1:0] ALU_control;
  logic                  illegal_instr;

  modport master (
    input  opcode, funct3, funct7b5, zero, negative, carry, overflow, mem_ready,
    output PC_write, IR_write, mem_read, mem_write, reg_write, address_select,
    output ALU_src_A, ALU_src_B, result_select, ALU_control, illegal_instr
  );

  modport slave (
    output opcode, funct3, funct7b5, zero, negative, carry, overflow, mem_ready,
    input  PC_write, IR_write, mem_read, mem_write, reg_write, address_select,
    input  ALU_src_A, ALU_src_B, result_select, ALU_control, illegal_instr
  );
endinterface

// File: rtl/alu_op_decoder.sv
// rtl/alu_op_decoder.sv - funct3/funct7b5 to ALU operation code
module alu_op_decoder
  import multicycle_controller_pkg::*;
#(
  parameter int ALU_CTRL_W = 4
) (
  input  logic [2:0]            funct3,
  input  logic                  funct7b5,
  input  logic                  is_rtype,
  output logic [ALU_CTRL_W-1:0] alu_control
);

  alu_op_t op;

  // Bit 30 selects SUB only for register ops (addi has no subtract form) but SRA for both
  always_comb begin
    op = ALU_ADD;
    case (funct3)
      3'b000:  op = (is_rtype && funct7b5) ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = funct7b5 ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
  end

  assign alu_control = ALU_CTRL_W'(op);

endmodule

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - RV32I multicycle control FSM
module multicycle_controller
  import multicycle_controller_pkg::*;
#(
  parameter int ALU_CTRL_W  = 4,
  parameter int FULL_BRANCH = 1,
  parameter int MEM_WAIT    = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  multicycle_controller_if.master bus
);

  state_t                state;
  state_t                state_nxt;
  logic                  mem_done;
  logic                  br_taken;
  logic                  br_legal;
  logic [ALU_CTRL_W-1:0] dec_alu;

  logic                  pc_write_c;
  logic                  ir_write_c;
  logic                  mem_read_c;
  logic                  mem_write_c;
  logic                  reg_write_c;
  logic                  addr_sel_c;
  logic [1:0]            src_a_c;
  logic [1:0]            src_b_c;
  logic [1:0]            res_sel_c;
  logic [ALU_CTRL_W-1:0] alu_c;

  assign mem_done = (MEM_WAIT == 0) ? 1'b1 : bus.mem_ready;

  alu_op_decoder #(
    .ALU_CTRL_W (ALU_CTRL_W)
  ) u_alu_op_decoder (
    .funct3      (bus.funct3),
    .funct7b5    (bus.funct7b5),
    .is_rtype    (state == S_EXEC_R),
    .alu_control (dec_alu)
  );

  // State register; reset returns to a fresh fetch regardless of the clock
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_FETCH;
    end else begin
      state <= state_nxt;
    end
  end

  // Branch condition from the SUB flags; funct3 010/011 never encode a branch
  always_comb begin
    br_taken = 1'b0;
    br_legal = 1'b1;
    case (bus.funct3)
      F3_BEQ:  br_taken = bus.zero;
      F3_BNE:  br_taken = ~bus.zero;
      F3_BLT:  br_taken = bus.negative ^ bus.overflow;
      F3_BGE:  br_taken = ~(bus.negative ^ bus.overflow);
      F3_BLTU: br_taken = ~bus.carry;
      F3_BGEU: br_taken = bus.carry;
      default: br_legal = 1'b0;
    endcase
    if ((FULL_BRANCH == 0) && (bus.funct3 != F3_BEQ) && (bus.funct3 != F3_BNE)) begin
      br_legal = 1'b0;
    end
  end

  // Next-state and per-state datapath controls
  always_comb begin
    state_nxt   = state;
    pc_write_c  = 1'b0;
    ir_write_c  = 1'b0;
    mem_read_c  = 1'b0;
    mem_write_c = 1'b0;
    reg_write_c = 1'b0;
    addr_sel_c  = ADDR_PC;
    src_a_c     = SRC_A_PC;
    src_b_c     = SRC_B_RS2;
    res_sel_c   = RES_ALU;
    alu_c       = ALU_CTRL_W'(ALU_ADD);
    case (state)
      S_FETCH: begin
        mem_read_c = 1'b1;
        src_b_c    = SRC_B_FOUR;
        if (mem_done) begin
          ir_write_c = 1'b1;
          pc_write_c = 1'b1;
          state_nxt  = S_DECODE;
        end
      end
      S_DECODE: begin
        src_a_c = SRC_A_OLD_PC;
        src_b_c = SRC_B_IMM;
        case (bus.opcode)
          OP_LOAD, OP_STORE: state_nxt = S_MEM_ADDR;
          OP_RTYPE:          state_nxt = S_EXEC_R;
          OP_ITYPE:          state_nxt = S_EXEC_I;
          OP_BRANCH:         state_nxt = S_BRANCH;
          OP_JAL, OP_JALR:   state_nxt = S_JUMP;
          OP_LUI, OP_AUIPC:  state_nxt = S_UPPER;
          default:           state_nxt = S_TRAP;
        endcase
      end
      S_MEM_ADDR: begin
        src_a_c   = SRC_A_RS1;
        src_b_c   = SRC_B_IMM;
        state_nxt = (bus.opcode == OP_LOAD) ? S_MEM_READ : S_MEM_WRITE;
      end
      S_MEM_READ: begin
        mem_read_c = 1'b1;
        addr_sel_c = ADDR_ALU;
        if (mem_done) begin
          state_nxt = S_MEM_WB;
        end
      end
      S_MEM_WB: begin
        reg_write_c = 1'b1;
        res_sel_c   = RES_MEM;
        state_nxt   = S_FETCH;
      end
      S_MEM_WRITE: begin
        mem_write_c = 1'b1;
        addr_sel_c  = ADDR_ALU;
        if (mem_done) begin
          state_nxt = S_FETCH;
        end
      end
      S_EXEC_R: begin
        src_a_c   = SRC_A_RS1;
        src_b_c   = SRC_B_RS2;
        alu_c     = dec_alu;
        state_nxt = S_ALU_WB;
      end
      S_EXEC_I: begin
        src_a_c   = SRC_A_RS1;
        src_b_c   = SRC_B_IMM;
        alu_c     = dec_alu;
        state_nxt = S_ALU_WB;
      end
      S_ALU_WB: begin
        reg_write_c = 1'b1;
        res_sel_c   = RES_ALU_OUT;
        state_nxt   = S_FETCH;
      end
      S_BRANCH: begin
        src_a_c   = SRC_A_RS1;
        src_b_c   = SRC_B_RS2;
        alu_c     = ALU_CTRL_W'(ALU_SUB);
        res_sel_c = RES_ALU_OUT;
        if (br_legal) begin
          pc_write_c = br_taken;
          state_nxt  = S_FETCH;
        end else begin
          state_nxt  = S_TRAP;
        end
      end
      S_JUMP: begin
        pc_write_c  = 1'b1;
        reg_write_c = 1'b1;
        src_a_c     = (bus.opcode == OP_JALR) ? SRC_A_RS1 : SRC_A_OLD_PC;
        src_b_c     = SRC_B_IMM;
        res_sel_c   = RES_ALU;
        state_nxt   = S_FETCH;
      end
      S_UPPER: begin
        reg_write_c = 1'b1;
        src_a_c     = (bus.opcode == OP_AUIPC) ? SRC_A_OLD_PC : SRC_A_PC;
        src_b_c     = SRC_B_IMM;
        state_nxt   = S_FETCH;
      end
      S_TRAP: begin
        state_nxt = S_TRAP;
      end
      default: begin
        state_nxt = S_FETCH;
      end
    endcase
  end

  // Reset low silences every strobe combinationally, even mid memory access
  assign bus.PC_write       = rst_n & pc_write_c;
  assign bus.IR_write       = rst_n & ir_write_c;
  assign bus.mem_read       = rst_n & mem_read_c;
  assign bus.mem_write      = rst_n & mem_write_c;
  assign bus.reg_write      = rst_n & reg_write_c;
  assign bus.address_select = rst_n & addr_sel_c;
  assign bus.ALU_src_A      = rst_n ? src_a_c : 2'b00;
  assign bus.ALU_src_B      = rst_n ? src_b_c : 2'b00;
  assign bus.result_select  = rst_n ? res_sel_c : 2'b00;
  assign bus.ALU_control    = rst_n ? alu_c : '0;
  // TRAP is only left through reset, so the flag is sticky by construction
  assign bus.illegal_instr  = rst_n & (state == S_TRAP);

endmodule
